// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: ROM/RAM address decode, 1-cycle registered reads,
// one write per wr strobe, and sticky protocol-error flags.
module mem_bus_responder #(
    parameter int unsigned           ADDR_W   = 13,
    parameter int unsigned           DATA_W   = 8,
    parameter int unsigned           RAM_AW   = 11,
    parameter logic [ADDR_W-1:0]     RAM_BASE = ADDR_W'(13'h1800)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              rd,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              err_collide,
    output logic              err_wprot,
    input  logic              err_clr
);

    localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WR_HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                data_oe_q, data_oe_d;
    logic                err_collide_q, err_collide_d;
    logic                err_wprot_q, err_wprot_d;
    logic                ram_we_c;
    logic [DATA_W-1:0]   ram_q [RAM_DEPTH];

    logic                is_ram_c;
    logic [RAM_AW-1:0]   ram_idx_c;
    logic [DATA_W-1:0]   rd_data_c;

    // Address decode and read-source mux
    assign rom_addr  = addr;
    assign is_ram_c  = (addr >= RAM_BASE);
    assign ram_idx_c = addr[RAM_AW-1:0];
    assign rd_data_c = is_ram_c ? ram_q[ram_idx_c] : rom_data;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            data_out_q    <= '0;
            data_oe_q     <= 1'b0;
            err_collide_q <= 1'b0;
            err_wprot_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            data_out_q    <= data_out_d;
            data_oe_q     <= data_oe_d;
            err_collide_q <= err_collide_d;
            err_wprot_q   <= err_wprot_d;
        end
    end

    // RAM array is deliberately left unreset; rst still blocks a coincident write
    always_ff @(posedge clk) begin
        if (!rst && ram_we_c) begin
            ram_q[ram_idx_c] <= data_in;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd && !wr)      state_d = READ;
                else if (wr && !rd) state_d = WR_HOLD;
            end
            READ: begin
                if (wr || !rd)      state_d = IDLE;
            end
            WR_HOLD: begin
                if (!wr)            state_d = IDLE;
            end
            default:                state_d = IDLE;
        endcase
    end

    // Output / datapath logic; error set takes precedence over err_clr
    always_comb begin
        data_out_d    = data_out_q;
        data_oe_d     = data_oe_q;
        err_collide_d = err_collide_q & ~err_clr;
        err_wprot_d   = err_wprot_q & ~err_clr;
        ram_we_c      = 1'b0;
        case (state_q)
            IDLE: begin
                data_oe_d = 1'b0;
                if (rd && wr) begin
                    err_collide_d = 1'b1;
                end else if (rd) begin
                    data_out_d = rd_data_c;
                    data_oe_d  = 1'b1;
                end else if (wr) begin
                    if (is_ram_c) ram_we_c    = 1'b1;
                    else          err_wprot_d = 1'b1;
                end
            end
            READ: begin
                if (wr) begin
                    err_collide_d = 1'b1;
                    data_oe_d     = 1'b0;
                end else if (rd) begin
                    data_out_d = rd_data_c;
                    data_oe_d  = 1'b1;
                end else begin
                    data_oe_d = 1'b0;
                end
            end
            WR_HOLD: begin
                data_oe_d = 1'b0;
                if (rd) err_collide_d = 1'b1;
            end
            default: begin
                data_out_d = '0;
                data_oe_d  = 1'b0;
            end
        endcase
    end

    assign data_out    = data_out_q;
    assign data_oe     = data_oe_q;
    assign err_collide = err_collide_q;
    assign err_wprot   = err_wprot_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed testbench for mem_bus_responder with a simple combinational ROM model.
module tb_mem_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] addr;
    logic        rd, wr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data;
    logic        err_collide, err_wprot, err_clr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ROM contents: low address byte XOR 8'hB5 (0x0010 -> A5, 0x0002 -> B7, 0x0100 -> B5)
    assign rom_data = rom_addr[7:0] ^ 8'hB5;

    mem_bus_responder dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .rd          (rd),
        .wr          (wr),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .err_collide (err_collide),
        .err_wprot   (err_wprot),
        .err_clr     (err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ram(input logic [12:0] a, input logic [7:0] d);
        addr = a; data_in = d; wr = 1'b1;
        tick();
        wr = 1'b0;
        tick();
    endtask

    task automatic read_chk(input string tag, input logic [12:0] a, input logic [7:0] exp);
        addr = a; rd = 1'b1;
        tick();
        check(tag, 32'(data_out), 32'(exp));
        check({tag, "_oe"}, 32'(data_oe), 32'd1);
        rd = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; data_in = '0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_oe", 32'(data_oe), 32'd0);
        check("rst_coll", 32'(err_collide), 32'd0);
        check("rst_wprot", 32'(err_wprot), 32'd0);

        // ROM read, one-cycle latency
        addr = 13'h0010; rd = 1'b1;
        #1 check("rom_addr", 32'(rom_addr), 32'h0010);
        tick();
        check("rom_dout", 32'(data_out), 32'hA5);
        check("rom_oe", 32'(data_oe), 32'd1);
        rd = 1'b0;
        tick();
        check("rom_oe_drop", 32'(data_oe), 32'd0);
        check("rom_dout_hold", 32'(data_out), 32'hA5);

        // Held wr writes once
        addr = 13'h1805; data_in = 8'h3C; wr = 1'b1;
        tick();
        data_in = 8'hFF;
        tick(); tick();
        wr = 1'b0;
        tick();
        read_chk("wr_once", 13'h1805, 8'h3C);
        check("wr_once_wprot", 32'(err_wprot), 32'd0);

        // Write to ROM region
        write_ram(13'h0100, 8'h77);
        check("wprot_set", 32'(err_wprot), 32'd1);
        tick();
        check("wprot_sticky", 32'(err_wprot), 32'd1);
        read_chk("rom_unchanged", 13'h0100, 8'hB5);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("wprot_clr", 32'(err_wprot), 32'd0);

        // rd/wr collision
        write_ram(13'h1800, 8'h11);
        addr = 13'h1800; data_in = 8'h99; rd = 1'b1; wr = 1'b1;
        tick();
        check("coll_set", 32'(err_collide), 32'd1);
        check("coll_oe", 32'(data_oe), 32'd0);
        rd = 1'b0; wr = 1'b0;
        tick();
        read_chk("coll_noram", 13'h1800, 8'h11);
        rd = 1'b1; wr = 1'b1; err_clr = 1'b1;
        tick();
        rd = 1'b0; wr = 1'b0;
        check("coll_set_wins", 32'(err_collide), 32'd1);
        tick();
        check("coll_clr", 32'(err_collide), 32'd0);
        err_clr = 1'b0;

        // Top of RAM and write blocked by rst
        write_ram(13'h1FFF, 8'h44);
        read_chk("ram_top", 13'h1FFF, 8'h44);
        write_ram(13'h1801, 8'h22);
        rst = 1'b1; addr = 13'h1801; data_in = 8'hEE; wr = 1'b1;
        tick();
        rst = 1'b0; wr = 1'b0;
        tick();
        read_chk("rst_blocks_wr", 13'h1801, 8'h22);

        // Streaming reads, then rst mid-sequence
        addr = 13'h1800; rd = 1'b1;
        tick();
        check("stream0", 32'(data_out), 32'h11);
        check("stream0_oe", 32'(data_oe), 32'd1);
        addr = 13'h1801;
        tick();
        check("stream1", 32'(data_out), 32'h22);
        check("stream1_oe", 32'(data_oe), 32'd1);
        addr = 13'h0002;
        tick();
        check("stream2", 32'(data_out), 32'hB7);
        check("stream2_oe", 32'(data_oe), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_oe", 32'(data_oe), 32'd0);
        check("mid_rst_dout", 32'(data_out), 32'd0);
        rst = 1'b0; rd = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
